// File: rtl/pipe_stage_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_if
// Bundles the upstream (in_*) and downstream (out_*) sides of a flow-controlled
// pipeline stage register.
//   slave  : the view of the stage itself (accepts in_*, produces out_*)
//   master : the view of the surrounding pipeline (produces in_*, consumes out_*)
// Signals:
//   in_valid / in_ready   upstream handshake
//   in_ctrl .. in_rd      payload offered by the execute side
//   out_valid / out_ready downstream handshake
//   out_ctrl .. out_rd    registered payload presented to the memory side
// -----------------------------------------------------------------------------
interface pipe_stage_reg_if #(
   parameter int DATA_W = 64,
   parameter int RD_W   = 5,
   parameter int CTRL_W = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_pc;
   logic [DATA_W-1:0] in_alu_result;
   logic              in_zero;
   logic [DATA_W-1:0] in_rs2_data;
   logic [RD_W-1:0]   in_rd;

   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_pc;
   logic [DATA_W-1:0] out_alu_result;
   logic              out_zero;
   logic [DATA_W-1:0] out_rs2_data;
   logic [RD_W-1:0]   out_rd;

   modport slave (
      input  in_valid, in_ctrl, in_pc, in_alu_result, in_zero, in_rs2_data, in_rd,
      input  out_ready,
      output in_ready,
      output out_valid, out_ctrl, out_pc, out_alu_result, out_zero, out_rs2_data, out_rd
   );

   modport master (
      output in_valid, in_ctrl, in_pc, in_alu_result, in_zero, in_rs2_data, in_rd,
      output out_ready,
      input  in_ready,
      input  out_valid, out_ctrl, out_pc, out_alu_result, out_zero, out_rs2_data, out_rd
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Flow-controlled pipeline stage register (EX/MEM by default). Carries the
// control bundle, PC, ALU result, zero flag, store data and rd with a valid
// bit, ready/valid back-pressure, flush, and an optional one-entry skid buffer
// that makes in_ready a flop output.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous, active-high reset
//   flush  drop every held entry and any word offered this cycle
//   bus    pipe_stage_reg_if.slave (upstream and downstream handshake + payload)
// Parameters:
//   DATA_W  width of PC, ALU result and store data
//   RD_W    destination register index width
//   CTRL_W  control width, [4:0] = {RegWrite, MemToReg, Branch, MemRead, MemWrite}
//   SKID    1 = skid buffer, registered in_ready; 0 = combinational in_ready
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int DATA_W = 64,
   parameter int RD_W   = 5,
   parameter int CTRL_W = 5,
   parameter bit SKID   = 1'b1
) (
   input logic             clock,
   input logic             reset,
   input logic             flush,
   pipe_stage_reg_if.slave bus
);

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] alu_result;
      logic              zero;
      logic [DATA_W-1:0] rs2_data;
      logic [RD_W-1:0]   rd;
   } payload_t;

   typedef enum logic [1:0] {
      EMPTY     = 2'd0,
      FULL      = 2'd1,
      SKID_FULL = 2'd2
   } state_e;

   payload_t in_word;
   payload_t main_q, main_d;
   logic     main_valid_q, main_valid_d;
   logic     in_ready_w;

   assign in_word = '{ctrl:       bus.in_ctrl,
                      pc:         bus.in_pc,
                      alu_result: bus.in_alu_result,
                      zero:       bus.in_zero,
                      rs2_data:   bus.in_rs2_data,
                      rd:         bus.in_rd};

   // Main (output) register, shared by both build options.
   // NOTE: sequential state is updated with <= so every flop samples the
   // pre-edge values; a blocking = here would make results depend on order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         main_q       <= '0;
         main_valid_q <= 1'b0;
      end else begin
         main_q       <= main_d;
         main_valid_q <= main_valid_d;
      end
   end

   generate
      if (SKID) begin : g_skid
         state_e   state_q, state_d;
         payload_t skid_q, skid_d;
         logic     in_ready_q;
         logic     accept, drain;

         assign accept = bus.in_valid && in_ready_q;
         assign drain  = main_valid_q && bus.out_ready;

         // NOTE: every signal written here gets its hold value first, so no
         // path through the case can leave it unassigned and infer a latch.
         always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            if (flush) begin
               // Flush wins over everything; data fields keep their contents.
               state_d = EMPTY;
            end else begin
               case (state_q)
                  EMPTY: begin
                     if (accept) begin
                        state_d = FULL;
                        main_d  = in_word;
                     end
                  end
                  FULL: begin
                     if (accept && drain) begin
                        main_d = in_word;
                     end else if (accept) begin
                        state_d = SKID_FULL;
                        skid_d  = in_word;
                     end else if (drain) begin
                        state_d = EMPTY;
                     end
                  end
                  SKID_FULL: begin
                     // in_ready is low here, so only the skid entry can advance.
                     if (drain) begin
                        state_d = FULL;
                        main_d  = skid_q;
                     end
                  end
                  default: state_d = EMPTY;
               endcase
            end
            main_valid_d = (state_d != EMPTY);
         end

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               state_q    <= EMPTY;
               skid_q     <= '0;
               in_ready_q <= 1'b1;
            end else begin
               state_q    <= state_d;
               skid_q     <= skid_d;
               // Registered copy of (next state != SKID_FULL): upstream never
               // sees a combinational path from out_ready.
               in_ready_q <= (state_d != SKID_FULL);
            end
         end

         assign in_ready_w = in_ready_q;
      end else begin : g_noskid
         logic accept, drain;

         assign in_ready_w = bus.out_ready || !main_valid_q;
         assign accept     = bus.in_valid && in_ready_w;
         assign drain      = main_valid_q && bus.out_ready;

         always_comb begin
            main_d       = main_q;
            main_valid_d = main_valid_q;
            if (flush) begin
               main_valid_d = 1'b0;
            end else if (accept) begin
               main_d       = in_word;
               main_valid_d = 1'b1;
            end else if (drain) begin
               main_valid_d = 1'b0;
            end
         end
      end
   endgenerate

   assign bus.in_ready       = in_ready_w;
   assign bus.out_valid      = main_valid_q;
   // A bubble must never write the register file or memory.
   assign bus.out_ctrl       = main_valid_q ? main_q.ctrl : '0;
   assign bus.out_pc         = main_q.pc;
   assign bus.out_alu_result = main_q.alu_result;
   assign bus.out_zero       = main_q.zero;
   assign bus.out_rs2_data   = main_q.rs2_data;
   assign bus.out_rd         = main_q.rd;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Directed bench for pipe_stage_reg. One instance with the skid buffer, one
// without. Stimulus pushes the words it expects to emerge into a queue per
// instance; a monitor per instance pops and compares on every output transfer
// and checks that bubbles carry zero control.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;
   localparam int DW = 64;
   localparam int RW = 5;
   localparam int CW = 5;

   typedef struct packed {
      logic [CW-1:0] ctrl;
      logic [DW-1:0] pc;
      logic [DW-1:0] alu;
      logic          zero;
      logic [DW-1:0] rs2;
      logic [RW-1:0] rd;
   } item_t;

   logic clock = 1'b0;
   logic reset;
   logic flush;

   always #5 clock = ~clock;

   pipe_stage_reg_if #(.DATA_W(DW), .RD_W(RW), .CTRL_W(CW)) bus1 ();
   pipe_stage_reg_if #(.DATA_W(DW), .RD_W(RW), .CTRL_W(CW)) bus0 ();

   pipe_stage_reg #(.DATA_W(DW), .RD_W(RW), .CTRL_W(CW), .SKID(1'b1)) dut1 (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .bus   (bus1)
   );

   pipe_stage_reg #(.DATA_W(DW), .RD_W(RW), .CTRL_W(CW), .SKID(1'b0)) dut0 (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .bus   (bus0)
   );

   item_t exp1[$];
   item_t exp0[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic item_t mk(input logic [DW-1:0] pc, input logic [DW-1:0] alu,
                                input logic [CW-1:0] ctrl);
      item_t it;
      it.ctrl = ctrl;
      it.pc   = pc;
      it.alu  = alu;
      it.zero = (alu == '0);
      it.rs2  = pc ^ 64'hA5A5_0000_5A5A_FFFF;
      it.rd   = pc[6:2];
      return it;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clock);
   endtask

   task automatic send1(input item_t it, input bit expect_out);
      bus1.in_valid      = 1'b1;
      bus1.in_ctrl       = it.ctrl;
      bus1.in_pc         = it.pc;
      bus1.in_alu_result = it.alu;
      bus1.in_zero       = it.zero;
      bus1.in_rs2_data   = it.rs2;
      bus1.in_rd         = it.rd;
      if (expect_out) exp1.push_back(it);
   endtask

   task automatic send0(input item_t it, input bit expect_out);
      bus0.in_valid      = 1'b1;
      bus0.in_ctrl       = it.ctrl;
      bus0.in_pc         = it.pc;
      bus0.in_alu_result = it.alu;
      bus0.in_zero       = it.zero;
      bus0.in_rs2_data   = it.rs2;
      bus0.in_rd         = it.rd;
      if (expect_out) exp0.push_back(it);
   endtask

   // Monitors: sampled on the falling edge, half a cycle from the active edge.
   always @(negedge clock) begin
      item_t got, want;
      if (!reset) begin
         if (bus1.out_valid && bus1.out_ready) begin
            got = {bus1.out_ctrl, bus1.out_pc, bus1.out_alu_result, bus1.out_zero,
                   bus1.out_rs2_data, bus1.out_rd};
            check("s1_out_expected", exp1.size() != 0, 1);
            if (exp1.size() != 0) begin
               want = exp1.pop_front();
               check("s1_out_word", got, want);
            end
         end else if (!bus1.out_valid) begin
            check("s1_bubble_ctrl", bus1.out_ctrl, 0);
         end
      end
   end

   always @(negedge clock) begin
      item_t got, want;
      if (!reset) begin
         if (bus0.out_valid && bus0.out_ready) begin
            got = {bus0.out_ctrl, bus0.out_pc, bus0.out_alu_result, bus0.out_zero,
                   bus0.out_rs2_data, bus0.out_rd};
            check("s0_out_expected", exp0.size() != 0, 1);
            if (exp0.size() != 0) begin
               want = exp0.pop_front();
               check("s0_out_word", got, want);
            end
         end else if (!bus0.out_valid) begin
            check("s0_bubble_ctrl", bus0.out_ctrl, 0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t limit 100000", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      flush = 1'b0;
      bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
      bus1.in_ctrl = '0; bus1.in_pc = '0; bus1.in_alu_result = '0;
      bus1.in_zero = 1'b0; bus1.in_rs2_data = '0; bus1.in_rd = '0;
      bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;
      bus0.in_ctrl = '0; bus0.in_pc = '0; bus0.in_alu_result = '0;
      bus0.in_zero = 1'b0; bus0.in_rs2_data = '0; bus0.in_rd = '0;

      // ---- reset state ----
      #2 reset = 1'b1;
      #1;
      check("rst_s1_in_ready", bus1.in_ready, 1);
      check("rst_s1_out_valid", bus1.out_valid, 0);
      check("rst_s1_out_ctrl", bus1.out_ctrl, 0);
      check("rst_s1_out_pc", bus1.out_pc, 0);
      check("rst_s0_in_ready", bus0.in_ready, 1);
      check("rst_s0_out_valid", bus0.out_valid, 0);
      tick();
      tick();
      reset = 1'b0;

      // ---- streaming, SKID=1, out_ready=1 ----
      bus1.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         send1(mk(64'h100 + 64'(4 * k), 64'h1000 + 64'(k), 5'b10010), 1'b1);
         at_neg();
         check("s1_stream_in_ready", bus1.in_ready, 1);
         if (k > 0) check("s1_stream_no_bubble", bus1.out_valid, 1);
         tick();
      end
      bus1.in_valid = 1'b0;
      at_neg();
      check("s1_stream_last_valid", bus1.out_valid, 1);
      check("s1_stream_last_pc", bus1.out_pc, 64'h108);
      tick();
      at_neg();
      check("s1_stream_empty", bus1.out_valid, 0);
      tick();

      // ---- back-pressure into the skid entry ----
      bus1.out_ready = 1'b0;
      send1(mk(64'h200, 64'hDEAD, 5'b10000), 1'b1);
      tick();
      send1(mk(64'h204, 64'h1234, 5'b10000), 1'b1);
      at_neg();
      check("s1_bp_ready_before_b", bus1.in_ready, 1);
      tick();
      bus1.in_valid = 1'b0;
      at_neg();
      check("s1_bp_skid_full_ready", bus1.in_ready, 0);
      check("s1_bp_hold_valid", bus1.out_valid, 1);
      check("s1_bp_hold_pc", bus1.out_pc, 64'h200);
      check("s1_bp_hold_alu", bus1.out_alu_result, 64'hDEAD);
      tick();
      at_neg();
      check("s1_bp_hold_pc_2", bus1.out_pc, 64'h200);
      tick();
      bus1.out_ready = 1'b1;
      at_neg();
      tick();
      at_neg();
      check("s1_bp_ready_after_drain", bus1.in_ready, 1);
      check("s1_bp_b_pc", bus1.out_pc, 64'h204);
      tick();
      at_neg();
      check("s1_bp_empty", bus1.out_valid, 0);
      tick();

      // ---- flush while SKID_FULL, word offered in the same cycle ----
      bus1.out_ready = 1'b0;
      send1(mk(64'h280, 64'h11, 5'b01001), 1'b1);
      tick();
      send1(mk(64'h284, 64'h22, 5'b01001), 1'b1);
      tick();
      bus1.in_valid = 1'b0;
      at_neg();
      check("s1_fl_skid_full", bus1.in_ready, 0);
      tick();
      send1(mk(64'h300, 64'h33, 5'b10011), 1'b0);
      flush = 1'b1;
      exp1.delete();
      tick();
      flush = 1'b0;
      bus1.in_valid = 1'b0;
      at_neg();
      check("s1_fl_out_valid", bus1.out_valid, 0);
      check("s1_fl_out_ctrl", bus1.out_ctrl, 0);
      check("s1_fl_in_ready", bus1.in_ready, 1);
      check("s1_fl_pc_kept", bus1.out_pc, 64'h280);
      tick();

      // ---- flush discards an input offered while in_ready=1 ----
      send1(mk(64'h320, 64'h44, 5'b10011), 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      bus1.in_valid = 1'b0;
      bus1.out_ready = 1'b1;
      at_neg();
      check("s1_fl_discard_valid", bus1.out_valid, 0);
      tick();

      // ---- simultaneous flush and drain ----
      send1(mk(64'h340, 64'h55, 5'b10010), 1'b1);
      tick();
      bus1.in_valid = 1'b0;
      flush = 1'b1;
      at_neg();
      check("s1_fd_valid_during", bus1.out_valid, 1);
      tick();
      flush = 1'b0;
      at_neg();
      check("s1_fd_empty_after", bus1.out_valid, 0);
      tick();

      // ---- bubble masking ----
      send1(mk(64'h400, 64'h77, 5'b10011), 1'b1);
      tick();
      bus1.in_valid = 1'b0;
      at_neg();
      check("s1_mask_ctrl_valid", bus1.out_ctrl, 5'b10011);
      tick();
      at_neg();
      check("s1_mask_valid", bus1.out_valid, 0);
      check("s1_mask_ctrl", bus1.out_ctrl, 0);
      check("s1_mask_pc_kept", bus1.out_pc, 64'h400);
      tick();

      // ---- asynchronous reset during traffic ----
      bus1.out_ready = 1'b0;
      send1(mk(64'h600, 64'h66, 5'b11111), 1'b1);
      tick();
      send1(mk(64'h604, 64'h67, 5'b11111), 1'b1);
      tick();
      bus1.in_valid = 1'b0;
      #1 reset = 1'b1;
      #1;
      check("s1_arst_valid", bus1.out_valid, 0);
      check("s1_arst_ctrl", bus1.out_ctrl, 0);
      check("s1_arst_pc", bus1.out_pc, 0);
      check("s1_arst_alu", bus1.out_alu_result, 0);
      check("s1_arst_rs2", bus1.out_rs2_data, 0);
      check("s1_arst_rd", bus1.out_rd, 0);
      check("s1_arst_zero", bus1.out_zero, 0);
      check("s1_arst_in_ready", bus1.in_ready, 1);
      exp1.delete();
      #1 reset = 1'b0;
      bus1.out_ready = 1'b1;
      tick();
      tick();
      at_neg();
      check("s1_arst_no_survivor", bus1.out_valid, 0);
      tick();

      // ---- SKID=0 build ----
      bus0.out_ready = 1'b0;
      send0(mk(64'h500, 64'h88, 5'b10100), 1'b1);
      #1;
      check("s0_empty_ready", bus0.in_ready, 1);
      tick();
      bus0.in_valid = 1'b0;
      #1;
      check("s0_stall_valid", bus0.out_valid, 1);
      check("s0_stall_ready", bus0.in_ready, 0);
      bus0.out_ready = 1'b1;
      #1;
      check("s0_comb_ready", bus0.in_ready, 1);
      send0(mk(64'h504, 64'h0, 5'b00010), 1'b1);
      at_neg();
      tick();
      bus0.in_valid = 1'b0;
      at_neg();
      check("s0_next_pc", bus0.out_pc, 64'h504);
      check("s0_next_zero", bus0.out_zero, 1);
      tick();
      at_neg();
      check("s0_drained", bus0.out_valid, 0);
      tick();
      send0(mk(64'h520, 64'h99, 5'b10011), 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      bus0.in_valid = 1'b0;
      at_neg();
      check("s0_flush_discard", bus0.out_valid, 0);
      tick();
      tick();

      check("s1_queue_drained", exp1.size(), 0);
      check("s0_queue_drained", exp0.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
